datacache_ctrl: RTL and testbench
=================================

DATACACHE_CTRL -- requirements
Module: datacache_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 11, SRAM index bits (2048 sets); LINE_BITS, default 128, data bits per line; TAG_BITS, default 17, tag width (32 - 11 - 4).
REQ-002 clock  in  1  single clock, rising-edge; all state changes on posedge clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_req_valid/cpu_req_ready  in/out  1  CPU request handshake; transfer when both high on a posedge.
REQ-005 cpu_req_addr  in  32  byte address; cpu_req_we in 1; cpu_req_wdata in 32; cpu_req_wstrb in 4.
REQ-006 cpu_rsp_valid  out  1  one-cycle response pulse; cpu_rsp_rdata out 32.
REQ-007 mem_req_valid/mem_req_ready  out/in  1  backing-memory handshake; mem_req_we out 1; mem_req_addr out 32 (line aligned); mem_req_wdata out 128.
REQ-008 mem_rsp_valid  in  1  refill data strobe; mem_rsp_rdata in 128.
REQ-009 sram_csb0, sram_web0  out  1  port-0 active-low select/write; sram_wmask0 out 16; sram_addr0 out 11; sram_din0 out 148; sram_dout0 in 148.
REQ-010 sram_csb1  out  1; sram_addr1 out 11; sram_dout1 in 148  port-1 read-only lookup port.

Function
REQ-011 SRAM line format SHALL be [147] valid, [146] dirty, [145:129] tag, [128] reserved 0, [127:0] data; index = addr[14:4], offset = addr[3:2].
REQ-012 SRAM read latency SHALL be treated as one cycle: address driven in cycle N, dout sampled at the posedge ending cycle N+1.
REQ-013 FSM states SHALL be IDLE, LOOKUP, WBACK, REFILL, FILL, RESP.
REQ-014 IDLE: cpu_req_ready=1; on accept, latch request, drive csb1=0 with index, go LOOKUP.
REQ-015 LOOKUP: hit = valid & tag match; read hit -> RESP with selected word; write hit -> port-0 write of merged line (byte strobes applied, dirty=1, wmask0=16'hFFFF) then RESP.
REQ-016 LOOKUP miss: victim valid & dirty -> WBACK; otherwise -> REFILL.
REQ-017 WBACK: hold mem_req_valid=1, we=1, victim tag/index address, victim data until mem_req_ready; then REFILL.
REQ-018 REFILL: hold mem_req_valid=1, we=0 until mem_req_ready; then wait for mem_rsp_valid, go FILL.
REQ-019 FILL: write line via port 0 (valid=1, dirty=we, tag, refill data merged with store if write); then RESP.
REQ-020 RESP: cpu_rsp_valid=1 exactly one cycle (writes also pulse, rdata=0); then IDLE.
REQ-021 Latency: hit response SHALL appear 2 cycles after accept; clean miss = 2 + mem handshake + mem response + 1 cycles.
REQ-022 cpu_req_ready SHALL be 0 in every state except IDLE; only one outstanding request.
REQ-023 mem_rsp_valid outside REFILL-wait SHALL be ignored.
REQ-024 Port 0 and port 1 SHALL never address the same index in the same cycle with a write pending read-back (write precedes next lookup by at least one cycle).

Reset
REQ-025 reset_n low SHALL force IDLE immediately, abort any in-flight miss, and drive: cpu_req_ready=0 during reset, cpu_rsp_valid=0, mem_req_valid=0, sram_csb0=1, sram_csb1=1, sram_web0=1, all data/address outputs 0.
REQ-026 SRAM contents SHALL not be cleared by the controller; a pre-zeroed SRAM is required at power-up.

Configuration
REQ-027 With DATACACHE_STATS_EN defined, 32-bit saturating hit_count, miss_count, wback_count outputs SHALL exist, reset to 0, incremented once per LOOKUP outcome/WBACK entry; without it, these ports and counters SHALL be absent.

Structure
REQ-028 Package dcache_pkg SHALL hold the FSM state enum, line-field bit positions, index/offset/tag width constants.
REQ-029 Sub-module datacache_stats SHALL implement the counters and be instantiated only under DATACACHE_STATS_EN.

Verification
REQ-030 Read miss, clean: read 0x0000_1004 to zeroed SRAM -> REFILL at 0x0000_1000, mem returns 128'h...DDDD_CCCC_BBBB_AAAA, rsp rdata=0xBBBB.
REQ-031 Read hit: repeat read 0x0000_1004 -> no mem request, rsp_valid 2 cycles after accept, rdata=0xBBBB.
REQ-032 Write hit with wstrb=4'b0011, wdata=0x1234_5678 to 0x0000_1000 -> line word0 = 0xAAAA_5678 (upper half retained), dirty=1.
REQ-033 Dirty eviction: read 0x0000_9000 (same index, new tag) -> WBACK addr 0x0000_1000 with modified line, then REFILL 0x0000_9000.
REQ-034 Stalled memory: mem_req_ready low 20 cycles -> mem_req fields stable, cpu_req_ready=0 throughout.
REQ-035 Reset asserted mid-REFILL -> all outputs at reset values same cycle; after release, new request accepted normally.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants and FSM state type for the direct-mapped data cache controller.
// Line layout: [valid][dirty][tag][reserved 0][data].
package dcache_pkg;

  localparam int DC_IDX_BITS  = 11;
  localparam int DC_LINE_BITS = 128;
  localparam int DC_TAG_BITS  = 17;
  localparam int DC_WORD_BITS = 32;
  localparam int DC_CNT_BITS  = 32;

  localparam int DC_BOFF_BITS = $clog2(DC_LINE_BITS / 8);
  localparam int DC_WOFF_BITS = $clog2(DC_LINE_BITS / DC_WORD_BITS);

  localparam int DC_SRAM_W    = DC_LINE_BITS + DC_TAG_BITS + 3;
  localparam int DC_VALID_POS = DC_SRAM_W - 1;
  localparam int DC_DIRTY_POS = DC_SRAM_W - 2;
  localparam int DC_TAG_LSB   = DC_LINE_BITS + 1;
  localparam int DC_RSVD_POS  = DC_LINE_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WBACK  = 3'd2,
    REFILL = 3'd3,
    FILL   = 3'd4,
    RESP   = 3'd5
  } dc_state_e;

endpackage

// File: rtl/datacache_stats.sv
// Saturating hit / miss / writeback event counters for datacache_ctrl.
module datacache_stats
  import dcache_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_hit,
  input  logic                   i_miss,
  input  logic                   i_wback,
  output logic [DC_CNT_BITS-1:0] o_hit_count,
  output logic [DC_CNT_BITS-1:0] o_miss_count,
  output logic [DC_CNT_BITS-1:0] o_wback_count
);

  logic [DC_CNT_BITS-1:0] r_hit;
  logic [DC_CNT_BITS-1:0] r_miss;
  logic [DC_CNT_BITS-1:0] r_wback;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit   <= '0;
      r_miss  <= '0;
      r_wback <= '0;
    end else begin
      if (i_hit && (r_hit != '1))     r_hit   <= r_hit + 1'b1;
      if (i_miss && (r_miss != '1))   r_miss  <= r_miss + 1'b1;
      if (i_wback && (r_wback != '1)) r_wback <= r_wback + 1'b1;
    end
  end

  assign o_hit_count   = r_hit;
  assign o_miss_count  = r_miss;
  assign o_wback_count = r_wback;

endmodule

// File: rtl/datacache_ctrl.sv
// Direct-mapped write-back data cache controller over a dual-port line SRAM.
// Define DATACACHE_STATS_EN to add hit_count/miss_count/wback_count outputs.
module datacache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_IDX_BITS,
  parameter int LINE_BITS  = DC_LINE_BITS,
  parameter int TAG_BITS   = DC_TAG_BITS
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cpu_req_valid,
  output logic                          cpu_req_ready,
  input  logic [31:0]                   cpu_req_addr,
  input  logic                          cpu_req_we,
  input  logic [31:0]                   cpu_req_wdata,
  input  logic [3:0]                    cpu_req_wstrb,
  output logic                          cpu_rsp_valid,
  output logic [31:0]                   cpu_rsp_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [31:0]                   mem_req_addr,
  output logic [LINE_BITS-1:0]          mem_req_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [LINE_BITS-1:0]          mem_rsp_rdata,
  output logic                          sram_csb0,
  output logic                          sram_web0,
  output logic [15:0]                   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]         sram_addr0,
  output logic [LINE_BITS+TAG_BITS+2:0] sram_din0,
  input  logic [LINE_BITS+TAG_BITS+2:0] sram_dout0,
  output logic                          sram_csb1,
  output logic [ADDR_WIDTH-1:0]         sram_addr1,
  input  logic [LINE_BITS+TAG_BITS+2:0] sram_dout1
`ifdef DATACACHE_STATS_EN
  ,
  output logic [DC_CNT_BITS-1:0]        hit_count,
  output logic [DC_CNT_BITS-1:0]        miss_count,
  output logic [DC_CNT_BITS-1:0]        wback_count
`endif
);

  localparam int BOFF_BITS = $clog2(LINE_BITS / 8);
  localparam int WOFF_BITS = $clog2(LINE_BITS / DC_WORD_BITS);
  localparam int SRAM_W    = LINE_BITS + TAG_BITS + 3;
  localparam int VALID_POS = SRAM_W - 1;
  localparam int DIRTY_POS = SRAM_W - 2;
  localparam int TAG_LSB   = LINE_BITS + 1;

  dc_state_e r_state;
  dc_state_e w_next;

  logic [31:0]           r_addr;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [LINE_BITS-1:0]  r_line;
  logic [TAG_BITS-1:0]   r_vtag;
  logic [31:0]           r_rdata;
  logic                  r_wait;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [WOFF_BITS-1:0]  w_off;
  logic                  w_hit;
  logic                  w_vdirty;
  logic [LINE_BITS-1:0]  w_lookup_data;
  logic [31:0]           w_lookup_word;
  logic [31:0]           w_refill_word;
  logic [LINE_BITS-1:0]  w_merge_src;
  logic [LINE_BITS-1:0]  w_merged;
  logic [LINE_BITS-1:0]  w_fill_line;
  logic                  w_unused;

  assign w_idx         = r_addr[BOFF_BITS +: ADDR_WIDTH];
  assign w_tag         = r_addr[31 -: TAG_BITS];
  assign w_off         = r_addr[BOFF_BITS-1:2];
  assign w_lookup_data = sram_dout1[LINE_BITS-1:0];
  assign w_hit         = sram_dout1[VALID_POS] && (sram_dout1[TAG_LSB +: TAG_BITS] == w_tag);
  assign w_vdirty      = sram_dout1[VALID_POS] && sram_dout1[DIRTY_POS];
  assign w_lookup_word = w_lookup_data[int'(w_off)*32 +: 32];
  assign w_refill_word = mem_rsp_rdata[int'(w_off)*32 +: 32];
  assign w_merge_src   = (r_state == LOOKUP) ? w_lookup_data : r_line;
  assign w_fill_line   = r_we ? w_merged : r_line;
  assign w_unused      = ^{r_addr[1:0], sram_dout0, sram_dout1[LINE_BITS]};

  // Store merge: only strobed bytes of the addressed word are replaced.
  always_comb begin
    w_merged = w_merge_src;
    for (int b = 0; b < 4; b++) begin
      if (r_wstrb[b]) w_merged[int'(w_off)*32 + b*8 +: 8] = r_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req_valid) w_next = LOOKUP;
      LOOKUP: begin
        if (w_hit)         w_next = RESP;
        else if (w_vdirty) w_next = WBACK;
        else               w_next = REFILL;
      end
      WBACK:   if (mem_req_ready) w_next = REFILL;
      REFILL:  if (r_wait && mem_rsp_valid) w_next = FILL;
      FILL:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_wait separates the REFILL request phase from the response wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_line  <= '0;
      r_vtag  <= '0;
      r_rdata <= '0;
      r_wait  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_valid) begin
            r_addr  <= cpu_req_addr;
            r_we    <= cpu_req_we;
            r_wdata <= cpu_req_wdata;
            r_wstrb <= cpu_req_wstrb;
            r_wait  <= 1'b0;
          end
        end
        LOOKUP: begin
          r_line  <= w_lookup_data;
          r_vtag  <= sram_dout1[TAG_LSB +: TAG_BITS];
          r_rdata <= (w_hit && !r_we) ? w_lookup_word : 32'd0;
        end
        REFILL: begin
          if (!r_wait) begin
            if (mem_req_ready) r_wait <= 1'b1;
          end else if (mem_rsp_valid) begin
            r_wait  <= 1'b0;
            r_line  <= mem_rsp_rdata;
            r_rdata <= r_we ? 32'd0 : w_refill_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset_n is low so that
  // cpu_req_ready does not advertise IDLE during reset.
  always_comb begin
    cpu_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    cpu_rsp_rdata = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    sram_csb0     = 1'b1;
    sram_web0     = 1'b1;
    sram_wmask0   = '0;
    sram_addr0    = '0;
    sram_din0     = '0;
    sram_csb1     = 1'b1;
    sram_addr1    = '0;
    if (reset_n) begin
      case (r_state)
        IDLE: begin
          cpu_req_ready = 1'b1;
          if (cpu_req_valid) begin
            sram_csb1  = 1'b0;
            sram_addr1 = cpu_req_addr[BOFF_BITS +: ADDR_WIDTH];
          end
        end
        LOOKUP: begin
          if (w_hit && r_we) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = w_idx;
            sram_din0   = {1'b1, 1'b1, w_tag, 1'b0, w_merged};
          end
        end
        WBACK: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = {r_vtag, w_idx, {BOFF_BITS{1'b0}}};
          mem_req_wdata = r_line;
        end
        REFILL: begin
          if (!r_wait) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {w_tag, w_idx, {BOFF_BITS{1'b0}}};
          end
        end
        FILL: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = w_idx;
          sram_din0   = {1'b1, r_we, w_tag, 1'b0, w_fill_line};
        end
        RESP: begin
          cpu_rsp_valid = 1'b1;
          cpu_rsp_rdata = r_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef DATACACHE_STATS_EN
  logic w_stat_hit;
  logic w_stat_miss;
  logic w_stat_wback;

  assign w_stat_hit   = (r_state == LOOKUP) && w_hit;
  assign w_stat_miss  = (r_state == LOOKUP) && !w_hit;
  assign w_stat_wback = (r_state == LOOKUP) && !w_hit && w_vdirty;

  datacache_stats u_stats (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_hit         (w_stat_hit),
    .i_miss        (w_stat_miss),
    .i_wback       (w_stat_wback),
    .o_hit_count   (hit_count),
    .o_miss_count  (miss_count),
    .o_wback_count (wback_count)
  );
`endif

endmodule

// File: tb/tb_datacache_ctrl.sv
// Directed bench for datacache_ctrl: behavioural SRAM, backing memory and a
// table of CPU transactions with hand-computed results.
module tb_datacache_ctrl;

  localparam int SW   = 148;
  localparam int NVEC = 15;

  logic          clock;
  logic          reset_n;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [31:0]   cpu_req_addr;
  logic          cpu_req_we;
  logic [31:0]   cpu_req_wdata;
  logic [3:0]    cpu_req_wstrb;
  logic          cpu_rsp_valid;
  logic [31:0]   cpu_rsp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [31:0]   mem_req_addr;
  logic [127:0]  mem_req_wdata;
  logic          mem_rsp_valid;
  logic [127:0]  mem_rsp_rdata;
  logic          sram_csb0;
  logic          sram_web0;
  logic [15:0]   sram_wmask0;
  logic [10:0]   sram_addr0;
  logic [SW-1:0] sram_din0;
  logic [SW-1:0] sram_dout0 = '0;
  logic          sram_csb1;
  logic [10:0]   sram_addr1;
  logic [SW-1:0] sram_dout1 = '0;

  logic [SW-1:0] sram [0:2047] = '{default: '0};
  logic [127:0]  bmem [logic [31:0]];

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0]  resRdata;
  int           resLat;
  logic         resWb;
  logic [31:0]  resWbAddr;
  logic [127:0] resWbData;
  logic         resRf;
  logic [31:0]  resRfAddr;
  logic         resStable;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [31:0]  expRdata;
    int           expLat;
    logic         expWb;
    logic [31:0]  expWbAddr;
    logic [127:0] expWbData;
    logic         expRf;
    logic [31:0]  expRfAddr;
  } vec_t;

  vec_t vecs [NVEC];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  datacache_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wstrb (cpu_req_wstrb),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .sram_csb0     (sram_csb0),
    .sram_web0     (sram_web0),
    .sram_wmask0   (sram_wmask0),
    .sram_addr0    (sram_addr0),
    .sram_din0     (sram_din0),
    .sram_dout0    (sram_dout0),
    .sram_csb1     (sram_csb1),
    .sram_addr1    (sram_addr1),
    .sram_dout1    (sram_dout1)
  );

  // One-cycle-latency dual-port SRAM model.
  always @(posedge clock) begin
    if (!sram_csb0 && !sram_web0) sram[sram_addr0] <= sram_din0;
    if (!sram_csb0) sram_dout0 <= sram[sram_addr0];
    if (!sram_csb1) sram_dout1 <= sram[sram_addr1];
  end

  function automatic logic [127:0] refillData(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {4{a}};
  endfunction

  function automatic vec_t mkVec(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic [31:0] rd, input int lat,
                                 input logic wb, input logic [31:0] wba, input logic [127:0] wbd,
                                 input logic rf, input logic [31:0] rfa);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = wd; v.wstrb = ws; v.expRdata = rd; v.expLat = lat;
    v.expWb = wb; v.expWbAddr = wba; v.expWbData = wbd; v.expRf = rf; v.expRfAddr = rfa;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ctrl"},
                {121'd0, cpu_req_ready, cpu_rsp_valid, mem_req_valid, mem_req_we,
                 sram_csb0, sram_web0, sram_csb1},
                128'b0000111);
    checkOutput({tag, " buses"},
                {127'd0, |{cpu_rsp_rdata, mem_req_addr, mem_req_wdata, sram_wmask0,
                           sram_addr0, sram_din0, sram_addr1}},
                128'd0);
  endtask

  // Issues one CPU request and plays the backing memory until the response.
  // The first memory request is held off for 'stall' cycles with spurious
  // response strobes that the controller must ignore.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int stall);
    int           stallLeft;
    logic         rspNext;
    logic         first;
    logic [31:0]  rfA;
    logic         sWe;
    logic [31:0]  sAddr;
    logic [127:0] sData;
    logic         done;
    resRdata = '0; resLat = -1; resWb = 1'b0; resWbAddr = '0; resWbData = '0;
    resRf = 1'b0; resRfAddr = '0; resStable = 1'b1;
    stallLeft = stall; rspNext = 1'b0; first = 1'b1; rfA = '0; done = 1'b0;
    sWe = 1'b0; sAddr = '0; sData = '0;
    @(negedge clock);
    cpu_req_valid = 1'b1; cpu_req_addr = addr; cpu_req_we = we;
    cpu_req_wdata = wdata; cpu_req_wstrb = wstrb;
    @(negedge clock);
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_we = 1'b0;
    cpu_req_wdata = '0; cpu_req_wstrb = '0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      if (cpu_rsp_valid) begin
        resRdata = cpu_rsp_rdata;
        resLat   = cyc;
        done     = 1'b1;
      end else begin
        if (cpu_req_ready) resStable = 1'b0;
        if (rspNext) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = refillData(rfA);
          rspNext = 1'b0;
        end
        if (mem_req_valid) begin
          if (stallLeft > 0) begin
            if (first) begin
              sWe = mem_req_we; sAddr = mem_req_addr; sData = mem_req_wdata; first = 1'b0;
            end else if ({mem_req_we, mem_req_addr, mem_req_wdata} !== {sWe, sAddr, sData}) begin
              resStable = 1'b0;
            end
            stallLeft--;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = {4{32'hBAD0_BAD0}};
          end else begin
            mem_req_ready = 1'b1;
            if (mem_req_we) begin
              resWb = 1'b1; resWbAddr = mem_req_addr; resWbData = mem_req_wdata;
              bmem[mem_req_addr] = mem_req_wdata;
            end else begin
              resRf = 1'b1; resRfAddr = mem_req_addr; rfA = mem_req_addr; rspNext = 1'b1;
            end
          end
        end else begin
          mem_req_ready = 1'b0;
        end
        @(negedge clock);
      end
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_we = 1'b0;
    cpu_req_wdata = '0; cpu_req_wstrb = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

    bmem[32'h0000_1000] = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    bmem[32'h0000_9000] = 128'h9999_0003_9999_0002_9999_0001_9999_0000;

    vecs[0]  = mkVec(32'h0000_1004, 0, 0, 0, 32'hBBBB_BBBB, 5, 0, 0, 0, 1, 32'h0000_1000);
    vecs[1]  = mkVec(32'h0000_1004, 0, 0, 0, 32'hBBBB_BBBB, 2, 0, 0, 0, 0, 0);
    vecs[2]  = mkVec(32'h0000_1000, 1, 32'h1234_5678, 4'b0011, 32'h0, 2, 0, 0, 0, 0, 0);
    vecs[3]  = mkVec(32'h0000_1000, 0, 0, 0, 32'hAAAA_5678, 2, 0, 0, 0, 0, 0);
    vecs[4]  = mkVec(32'h0000_9000, 0, 0, 0, 32'h9999_0000, 6,
                     1, 32'h0000_1000, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_5678,
                     1, 32'h0000_9000);
    vecs[5]  = mkVec(32'h0000_100C, 0, 0, 0, 32'hDDDD_DDDD, 5, 0, 0, 0, 1, 32'h0000_1000);
    vecs[6]  = mkVec(32'h0000_2008, 1, 32'hCAFE_F00D, 4'b1111, 32'h0, 5, 0, 0, 0, 1, 32'h0000_2000);
    vecs[7]  = mkVec(32'h0000_2008, 0, 0, 0, 32'hCAFE_F00D, 2, 0, 0, 0, 0, 0);
    vecs[8]  = mkVec(32'h0000_2004, 0, 0, 0, 32'h0000_2000, 2, 0, 0, 0, 0, 0);
    vecs[9]  = mkVec(32'h0000_200C, 1, 32'hAABB_CCDD, 4'b1100, 32'h0, 2, 0, 0, 0, 0, 0);
    vecs[10] = mkVec(32'h0000_A000, 0, 0, 0, 32'h0000_A000, 6,
                     1, 32'h0000_2000, 128'hAABB_2000_CAFE_F00D_0000_2000_0000_2000,
                     1, 32'h0000_A000);
    vecs[11] = mkVec(32'h0000_7FF4, 0, 0, 0, 32'h0000_7FF0, 5, 0, 0, 0, 1, 32'h0000_7FF0);
    vecs[12] = mkVec(32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFF0, 5, 0, 0, 0, 1, 32'hFFFF_FFF0);
    vecs[13] = mkVec(32'hFFFF_FFFC, 1, 32'h0000_00EE, 4'b0001, 32'h0, 2, 0, 0, 0, 0, 0);
    vecs[14] = mkVec(32'h0000_7FF8, 0, 0, 0, 32'h0000_7FF0, 6,
                     1, 32'hFFFF_FFF0, 128'hFFFF_FFEE_FFFF_FFF0_FFFF_FFF0_FFFF_FFF0,
                     1, 32'h0000_7FF0);

    #12;
    checkResetState("reset idle");
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_1004;
    #1;
    checkResetState("reset with valid");
    cpu_req_valid = 1'b0; cpu_req_addr = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("ready after reset", {127'd0, cpu_req_ready}, 128'd1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wstrb, 0);
      checkOutput($sformatf("v%0d latency", i), 128'(resLat), 128'(vecs[i].expLat));
      checkOutput($sformatf("v%0d rdata", i), {96'd0, resRdata}, {96'd0, vecs[i].expRdata});
      checkOutput($sformatf("v%0d ready low", i), {127'd0, resStable}, 128'd1);
      checkOutput($sformatf("v%0d wback seen", i), {127'd0, resWb}, {127'd0, vecs[i].expWb});
      checkOutput($sformatf("v%0d refill seen", i), {127'd0, resRf}, {127'd0, vecs[i].expRf});
      if (vecs[i].expWb) begin
        checkOutput($sformatf("v%0d wback addr", i), {96'd0, resWbAddr}, {96'd0, vecs[i].expWbAddr});
        checkOutput($sformatf("v%0d wback data", i), resWbData, vecs[i].expWbData);
      end
      if (vecs[i].expRf) begin
        checkOutput($sformatf("v%0d refill addr", i), {96'd0, resRfAddr}, {96'd0, vecs[i].expRfAddr});
      end
    end

    // Memory holds off the refill for 20 cycles with junk response strobes.
    applyStimulus(32'h0000_3000, 1'b0, 32'h0, 4'h0, 20);
    checkOutput("stall latency", 128'(resLat), 128'd25);
    checkOutput("stall rdata", {96'd0, resRdata}, {96'd0, 32'h0000_3000});
    checkOutput("stall fields stable", {127'd0, resStable}, 128'd1);
    checkOutput("stall refill addr", {96'd0, resRfAddr}, {96'd0, 32'h0000_3000});

    // Reset lands while the controller is waiting in REFILL.
    @(negedge clock);
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_4000; cpu_req_we = 1'b0;
    @(negedge clock);
    cpu_req_valid = 1'b0; cpu_req_addr = '0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_req_valid) seen = 1'b1;
      else @(negedge clock);
    end
    checkOutput("midrefill reached", {127'd0, seen}, 128'd1);
    checkOutput("midrefill addr", {96'd0, mem_req_addr}, {96'd0, 32'h0000_4000});
    #2 reset_n = 1'b0;
    #1;
    checkResetState("midrefill reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("ready after midrefill", {127'd0, cpu_req_ready}, 128'd1);
    applyStimulus(32'h0000_4004, 1'b0, 32'h0, 4'h0, 0);
    checkOutput("post reset latency", 128'(resLat), 128'd5);
    checkOutput("post reset rdata", {96'd0, resRdata}, {96'd0, 32'h0000_4000});
    checkOutput("post reset refill addr", {96'd0, resRfAddr}, {96'd0, 32'h0000_4000});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
